// File: rtl/and_gate.sv
// Parameterised bitwise AND gate with reduction flags, a registered result copy
// and a saturating counter of all-ones rising edges. AND_GATE_REG_OUT_EN registers C.
module and_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             c_all,
    output logic             c_any,
    output logic [WIDTH-1:0] c_q,
    output logic [CNT_W-1:0] rise_cnt
);

    logic [WIDTH-1:0] r;
    logic             all_d;
    logic             rise;

    // Independent per-bit lanes; plain & keeps Verilog X/Z propagation.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign r[i] = A[i] & B[i];
    end

    assign c_all = &r;
    assign c_any = |r;
    assign rise  = c_all & ~all_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q   <= '0;
            all_d <= 1'b0;
        end else begin
            c_q   <= r;
            all_d <= c_all;
        end
    end

    // Saturates at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rise_cnt <= '0;
        else if (rise && (rise_cnt != {CNT_W{1'b1}}))
            rise_cnt <= rise_cnt + CNT_W'(1);
    end

`ifdef AND_GATE_REG_OUT_EN
    assign C = c_q;
`else
    assign C = r;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: truth table, 8-bit patterns, registered path
// scoreboard, rise counter with saturation, asynchronous reset.
module tb_and_gate;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic [0:0] c1, cq1;
    logic       all1, any1;
    logic [7:0] cnt1;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] c8, cq8, cnt8, c8s, cq8s;
    logic       all8, any8, all8s, any8s;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] prev_q = '0;
    logic       m_all_d = 1'b0;
    int         m_cnt8 = 0;
    int         m_cnt2 = 0;

    always #5 clk = ~clk;

    and_gate #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .C(c1), .A(a1), .B(b1),
        .c_all(all1), .c_any(any1), .c_q(cq1), .rise_cnt(cnt1));

    and_gate #(.WIDTH(8), .CNT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .C(c8), .A(a8), .B(b8),
        .c_all(all8), .c_any(any8), .c_q(cq8), .rise_cnt(cnt8));

    and_gate #(.WIDTH(8), .CNT_W(2)) u8s (
        .clk(clk), .rst_n(rst_n), .C(c8s), .A(a8), .B(b8),
        .c_all(all8s), .c_any(any8s), .c_q(cq8s), .rise_cnt(cnt2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model of one rising edge: all-ones sampled against the previous sample.
    task automatic model_edge(input logic [7:0] r);
        if ((&r) && !m_all_d) begin
            m_cnt8 = (m_cnt8 == 255) ? 255 : m_cnt8 + 1;
            m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
        end
        m_all_d = &r;
    endtask

    // Drive between edges, check comb outputs and held c_q, then check after the edge.
    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [7:0] e;
        a8 = a;
        b8 = b;
        exp_q.push_back(a & b);
        #1;
`ifdef AND_GATE_REG_OUT_EN
        check({tag, ".C_hold"}, 32'(c8), 32'(prev_q));
`else
        check({tag, ".C"}, 32'(c8), 32'(a & b));
`endif
        check({tag, ".c_all"}, 32'(all8), 32'(&(a & b)));
        check({tag, ".c_any"}, 32'(any8), 32'(|(a & b)));
        check({tag, ".cq_hold"}, 32'(cq8), 32'(prev_q));
        @(posedge clk);
        #1;
        model_edge(a & b);
        e = exp_q.pop_front();
        prev_q = e;
        check({tag, ".c_q"}, 32'(cq8), 32'(e));
`ifdef AND_GATE_REG_OUT_EN
        check({tag, ".C_reg"}, 32'(c8), 32'(e));
`endif
        check({tag, ".cnt8"}, 32'(cnt8), 32'(m_cnt8));
        check({tag, ".cnt2"}, 32'(cnt2), 32'(m_cnt2));
    endtask

    initial begin
        // Reset state
        #2;
        check("rst.cq8", 32'(cq8), 32'h0);
        check("rst.cnt8", 32'(cnt8), 32'h0);
        check("rst.cnt2", 32'(cnt2), 32'h0);
        check("rst.cq1", 32'(cq1), 32'h0);
        rst_n = 1'b1;

        // Truth table and X handling on the 1-bit instance
        a1 = 1'b0; b1 = 1'b0; #10;
`ifndef AND_GATE_REG_OUT_EN
        check("tt00", 32'(c1), 32'h0);
        a1 = 1'b0; b1 = 1'b1; #10;
        check("tt01", 32'(c1), 32'h0);
        a1 = 1'b1; b1 = 1'b0; #10;
        check("tt10", 32'(c1), 32'h0);
        a1 = 1'b1; b1 = 1'b1; #10;
        check("tt11", 32'(c1), 32'h1);
        check("tt11.all", 32'(all1), 32'h1);
        check("tt11.any", 32'(any1), 32'h1);
        a1 = 1'b0; b1 = 1'bx; #10;
        check("tt0x", 32'(c1), 32'h0);
        a1 = 1'b1; b1 = 1'bx; #10;
        check("tt1x", {31'h0, c1}, {31'h0, 1'bx});
`endif
        a1 = 1'b0; b1 = 1'b0;

        // Align to just after an edge, then run the 8-bit sequence
        @(posedge clk);
        #1;
        prev_q = cq8;
        m_all_d = 1'b0;
        drive8(8'hF0, 8'h3C, "p_f0_3c");
        drive8(8'hFF, 8'hFF, "p_ff_a");
        drive8(8'h00, 8'h5A, "p_00");
        drive8(8'hFF, 8'hFF, "p_ff_b");
        check("cnt_two", 32'(cnt8), 32'h2);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.cq8", 32'(cq8), 32'h0);
        check("arst.cnt8", 32'(cnt8), 32'h0);
        check("arst.cnt2", 32'(cnt2), 32'h0);
`ifdef AND_GATE_REG_OUT_EN
        check("arst.C", 32'(c8), 32'h0);
`else
        check("arst.C", 32'(c8), 32'hFF);
`endif
        check("arst.all", 32'(all8), 32'h1);
        @(posedge clk);
        #1;
        check("arst.hold", 32'(cnt8), 32'h0);
        exp_q.delete();
        prev_q = '0;
        m_all_d = 1'b0;
        m_cnt8 = 0;
        m_cnt2 = 0;
        rst_n = 1'b1;

        // First edge after release with all-ones counts
        drive8(8'hFF, 8'hFF, "post_rst");
        check("post_rst.one", 32'(cnt8), 32'h1);
        drive8(8'hA5, 8'hA5, "p_a5");

        // Glitch to all-ones entirely between edges is not counted
        a8 = 8'hFF; b8 = 8'hFF; #2;
        drive8(8'h0F, 8'hFF, "glitch");

        drive8(8'hFF, 8'hFF, "r2");
        drive8(8'h00, 8'h00, "f2");
        drive8(8'hFF, 8'hFF, "r3");
        drive8(8'h01, 8'h01, "f3");
        drive8(8'hFF, 8'hFF, "r4");
        drive8(8'h80, 8'hFF, "f4");
        drive8(8'hFF, 8'hFF, "r5");
        check("sat.cnt8", 32'(cnt8), 32'h5);
        check("sat.cnt2", 32'(cnt2), 32'h3);
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
